// File: rtl/coe_buf_ctrl_if.sv
// coe_buf_ctrl_if: writer stream, reader stream and both RAM ports of the ping-pong buffer.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 4
`endif
interface coe_buf_ctrl_if #(parameter int AW = 9, parameter int DW = `PIXEL_WIDTH*8);
  logic          wr_valid;
  logic [1:0]    wr_half;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_ready;
  logic [1:0]    ram_a_we;
  logic [AW-1:0] ram_a_addr;
  logic [DW-1:0] ram_a_data;
  logic          ram_b_re;
  logic [AW-1:0] ram_b_addr;
  logic [DW-1:0] ram_b_data;
  modport master (
    input  wr_valid, wr_half, wr_data, wr_last, rd_ready, ram_b_data,
    output wr_ready, rd_valid, rd_data, rd_last, ram_a_we, ram_a_addr, ram_a_data, ram_b_re, ram_b_addr
  );
  modport slave (
    output wr_valid, wr_half, wr_data, wr_last, rd_ready, ram_b_data,
    input  wr_ready, rd_valid, rd_data, rd_last, ram_a_we, ram_a_addr, ram_a_data, ram_b_re, ram_b_addr
  );
endinterface

// File: rtl/coe_buf_ctrl.sv
// coe_buf_ctrl: two-bank ping-pong buffer controller with a 2-entry output skid buffer.
// Define COE_BUF_OVF_ERR_EN to get the sticky err_ovf output for blocks forced closed at 256 words.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 4
`endif
module coe_buf_ctrl #(parameter int BANK_AW = 8) (
  input  logic clk,
  input  logic rst_n,
`ifdef COE_BUF_OVF_ERR_EN
  output logic err_ovf,
`endif
  coe_buf_ctrl_if.master bus
);
  localparam int LW = BANK_AW + 1;
  localparam int DW = `PIXEL_WIDTH*8;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;
  bank_st_e st_q [2];
  bank_st_e st_d [2];
  logic [LW-1:0] len_q [2];
  logic [LW-1:0] len_d [2];
  logic wbank_q, wbank_d, rbank_q, rbank_d;
  logic [BANK_AW-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] rcnt_q, rcnt_d;
  logic [DW-1:0] sk_data_q [2];
  logic [DW-1:0] sk_data_d [2];
  logic sk_last_q [2];
  logic sk_last_d [2];
  logic [1:0] sk_cnt_q, sk_cnt_d;
  logic inf_q, inf_last_q;
  logic acc, close, re, last_rd, pop;
  logic [DW-1:0] it1_data;
  logic it1_last;
  assign bus.wr_ready = st_q[wbank_q] == EMPTY || st_q[wbank_q] == FILLING;
  assign acc = bus.wr_valid && bus.wr_ready && bus.wr_half != 2'b11;
  assign close = acc && (bus.wr_last || &wcnt_q);
  // the word already in flight from the RAM reserves a skid slot
  assign re = (st_q[rbank_q] == FULL || st_q[rbank_q] == DRAINING) && rcnt_q < len_q[rbank_q]
              && (3'(sk_cnt_q) + 3'(inf_q)) < 3'd2;
  assign last_rd = re && rcnt_q == len_q[rbank_q] - LW'(1);
  assign pop = bus.rd_valid && bus.rd_ready;
  assign bus.ram_a_we = acc ? bus.wr_half : 2'b11;
  assign bus.ram_a_addr = {wbank_q, wcnt_q};
  assign bus.ram_a_data = bus.wr_data;
  assign bus.ram_b_re = re;
  assign bus.ram_b_addr = {rbank_q, rcnt_q[BANK_AW-1:0]};
  // an empty skid buffer falls through to the word arriving from the RAM
  assign bus.rd_valid = sk_cnt_q != 2'd0 || inf_q;
  assign bus.rd_data = sk_cnt_q != 2'd0 ? sk_data_q[0] : bus.ram_b_data;
  assign bus.rd_last = sk_cnt_q != 2'd0 ? sk_last_q[0] : inf_last_q;
  assign it1_data = sk_cnt_q > 2'd1 ? sk_data_q[1] : bus.ram_b_data;
  assign it1_last = sk_cnt_q > 2'd1 ? sk_last_q[1] : inf_last_q;
  always_comb begin
    st_d = st_q;
    len_d = len_q;
    wbank_d = wbank_q;
    wcnt_d = wcnt_q;
    rbank_d = rbank_q;
    rcnt_d = rcnt_q;
    if (acc) begin
      st_d[wbank_q] = close ? FULL : FILLING;
      wcnt_d = close ? '0 : wcnt_q + BANK_AW'(1);
      wbank_d = wbank_q ^ close;
      if (close) len_d[wbank_q] = LW'(wcnt_q) + LW'(1);
    end
    if (re) begin
      st_d[rbank_q] = last_rd ? EMPTY : DRAINING;
      rcnt_d = last_rd ? '0 : rcnt_q + LW'(1);
      rbank_d = rbank_q ^ last_rd;
    end
    sk_data_d[0] = pop ? it1_data : bus.rd_data;
    sk_last_d[0] = pop ? it1_last : bus.rd_last;
    sk_data_d[1] = pop ? bus.ram_b_data : it1_data;
    sk_last_d[1] = pop ? inf_last_q : it1_last;
    sk_cnt_d = sk_cnt_q + 2'(inf_q) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= '{EMPTY, EMPTY};
      len_q <= '{'0, '0};
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      sk_data_q <= '{'0, '0};
      sk_last_q <= '{1'b0, 1'b0};
      sk_cnt_q <= '0;
      inf_q <= 1'b0;
      inf_last_q <= 1'b0;
    end else begin
      st_q <= st_d;
      len_q <= len_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      sk_data_q <= sk_data_d;
      sk_last_q <= sk_last_d;
      sk_cnt_q <= sk_cnt_d;
      inf_q <= re;
      inf_last_q <= last_rd;
    end
  end
`ifdef COE_BUF_OVF_ERR_EN
  logic err_ovf_q;
  always_ff @(posedge clk) begin
    if (!rst_n) err_ovf_q <= 1'b0;
    else if (acc && &wcnt_q && !bus.wr_last) err_ovf_q <= 1'b1;
  end
  assign err_ovf = err_ovf_q;
`endif
endmodule

// File: tb/tb_coe_buf_ctrl.sv
// tb_coe_buf_ctrl: randomized and directed stimulus against a block-queue scoreboard model.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 4
`endif
module tb_coe_buf_ctrl;
  localparam int DW = `PIXEL_WIDTH*8;
  localparam int BW = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int rd_mode = 0;
  coe_buf_ctrl_if #(.AW(9), .DW(DW)) bus ();
`ifdef COE_BUF_OVF_ERR_EN
  logic err_ovf;
  bit ovf_exp;
`endif
  coe_buf_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef COE_BUF_OVF_ERR_EN
    .err_ovf(err_ovf),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (bus.ram_a_we != 2'b11) mem[bus.ram_a_addr] <= bus.ram_a_data;
    if (bus.ram_b_re) bus.ram_b_data <= mem[bus.ram_b_addr];
  end
  initial begin
    bus.rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0: bus.rd_ready = 1'b1;
        1: bus.rd_ready = 1'b0;
        2: bus.rd_ready = ~bus.rd_ready;
        default: bus.rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end
  typedef struct {logic [DW-1:0] d; logic l;} exp_t;
  typedef struct {int bank; int len;} blk_t;
  exp_t sb [$];
  blk_t blkq [$];
  bit busy [2];
  int m_wbank, m_wcnt, m_rcnt;
  bit hold_v;
  logic [DW-1:0] hold_d;
  logic hold_l;
  always @(negedge clk) begin
    bit exp_rdy, acc, lst;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      blkq.delete();
      busy = '{0, 0};
      m_wbank = 0;
      m_wcnt = 0;
      m_rcnt = 0;
      hold_v = 0;
`ifdef COE_BUF_OVF_ERR_EN
      ovf_exp = 0;
`endif
    end else begin
      exp_rdy = !busy[m_wbank];
      check("wr_ready", bus.wr_ready, exp_rdy);
      acc = bus.wr_valid && exp_rdy && bus.wr_half != 2'b11;
      check("ram_a_we", bus.ram_a_we, acc ? bus.wr_half : 2'b11);
      if (acc) begin
        check("ram_a_addr", bus.ram_a_addr, m_wbank * BW + m_wcnt);
        lst = bus.wr_last || m_wcnt == BW - 1;
        sb.push_back('{bus.wr_data, lst});
        if (lst) begin
          busy[m_wbank] = 1;
          blkq.push_back('{m_wbank, m_wcnt + 1});
`ifdef COE_BUF_OVF_ERR_EN
          if (!bus.wr_last) ovf_exp = 1;
`endif
          m_wbank ^= 1;
          m_wcnt = 0;
        end else m_wcnt++;
      end
      if (bus.ram_b_re) begin
        if (blkq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL read_issue: got ram_b_re=1 addr 0x%0h required no read (no full bank)", bus.ram_b_addr);
        end else begin
          check("ram_b_addr", bus.ram_b_addr, blkq[0].bank * BW + m_rcnt);
          m_rcnt++;
          if (m_rcnt == blkq[0].len) begin
            busy[blkq[0].bank] = 0;
            void'(blkq.pop_front());
            m_rcnt = 0;
          end
        end
      end
      if (hold_v) begin
        check("hold_valid", bus.rd_valid, 1'b1);
        check("hold_data", bus.rd_data, hold_d);
        check("hold_last", bus.rd_last, hold_l);
      end
      hold_v = bus.rd_valid && !bus.rd_ready;
      hold_d = bus.rd_data;
      hold_l = bus.rd_last;
      if (bus.rd_valid && bus.rd_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_extra: got word 0x%0h required none", bus.rd_data);
        end else begin
          e = sb.pop_front();
          check("rd_data", bus.rd_data, e.d);
          check("rd_last", bus.rd_last, e.l);
        end
      end
`ifdef COE_BUF_OVF_ERR_EN
      check("err_ovf", err_ovf, ovf_exp);
`endif
    end
  end
  task automatic wr_word(input logic [DW-1:0] d, input logic l, input logic [1:0] h);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data = d;
    bus.wr_last = l;
    bus.wr_half = h;
    @(negedge clk);
    while (!bus.wr_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL wr_timeout: got wr_ready=0 for %0d cycles required 1", n);
    end
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.rd_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", n < 3000, 1'b1);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic check_reset_state(string tag);
    check({tag, "_wr_ready"}, bus.wr_ready, 1'b1);
    check({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
    check({tag, "_rd_last"}, bus.rd_last, 1'b0);
    check({tag, "_ram_b_re"}, bus.ram_b_re, 1'b0);
    check({tag, "_ram_a_we"}, bus.ram_a_we, 2'b11);
    check({tag, "_ram_a_addr"}, bus.ram_a_addr, 9'd0);
    check({tag, "_ram_b_addr"}, bus.ram_b_addr, 9'd0);
`ifdef COE_BUF_OVF_ERR_EN
    check({tag, "_err_ovf"}, err_ovf, 1'b0);
`endif
  endtask
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_half = 2'b00;
    bus.wr_data = '0;
    bus.wr_last = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rd_mode = 0;
    for (int i = 0; i < 16; i++) wr_word(DW'(i), i == 15, 2'b00);
    @(negedge clk);
    check("lat_ram_b_re", bus.ram_b_re, 1'b1);
    @(negedge clk);
    check("lat_rd_valid", bus.rd_valid, 1'b1);
    check("lat_rd_data", bus.rd_data, '0);
    @(posedge clk);
    #1;
    drain();
    rd_mode = 1;
    for (int i = 0; i < 8; i++) wr_word(DW'(32'hA0 + i), i == 7, 2'b00);
    for (int i = 0; i < 4; i++) wr_word(DW'(32'hB0 + i), i == 3, 2'b00);
    @(negedge clk);
    check("both_full_wr_ready", bus.wr_ready, 1'b0);
    check("both_full_rd_valid", bus.rd_valid, 1'b1);
    @(posedge clk);
    #1;
    rd_mode = 0;
    drain();
    rd_mode = 2;
    for (int i = 0; i < 32; i++) wr_word(DW'($urandom), i == 31, 2'b00);
    drain();
    rd_mode = 0;
    for (int i = 0; i < 3; i++) wr_word(DW'(32'hC0 + i), 1'b0, 2'b01);
    wr_word(DW'(32'hCF), 1'b1, 2'b11);
    repeat (4) begin
      @(negedge clk);
      check("nop_last_no_read", bus.ram_b_re, 1'b0);
    end
    @(posedge clk);
    #1;
    wr_word(DW'(32'hC3), 1'b1, 2'b00);
    drain();
    rd_mode = 3;
    for (int b = 0; b < 6; b++) begin
      int len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        wr_word(DW'($urandom), i == len - 1, ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00);
      end
    end
    wr_word(DW'($urandom), 1'b1, 2'b00);
    drain();
    do_reset();
    for (int i = 0; i < 300; i++) wr_word(DW'($urandom), 1'b0, 2'b00);
    wr_word(DW'($urandom), 1'b1, 2'b00);
`ifdef COE_BUF_OVF_ERR_EN
    check("ovf_sticky", err_ovf, 1'b1);
`endif
    drain();
    rd_mode = 0;
    for (int i = 0; i < 20; i++) wr_word(DW'(32'hD0 + i), i == 19, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("mid_drain_reset");
    repeat (3) @(negedge clk);
    check("post_reset_idle", bus.rd_valid, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/coe_buf_ctrl.md
COE_BUF_CTRL -- requirements
Module: coe_buf_ctrl

Interface
REQ-001 Parameter BANK_AW, default 8, address width of one bank; RAM depth = 2**(BANK_AW+1) = 512.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 wr_valid  input  1  writer word valid.
REQ-005 wr_half  input  2  half-word write mode, passed to RAM port A (00 full, 01/10 half, 11 invalid).
REQ-006 wr_data  input  `PIXEL_WIDTH*8  write word.
REQ-007 wr_last  input  1  last word of current block.
REQ-008 wr_ready  output  1  controller accepts the write word this cycle.
REQ-009 rd_valid / rd_data / rd_last  output  1 / `PIXEL_WIDTH*8 / 1  read stream, last flags final word of a bank.
REQ-010 rd_ready  input  1  reader accepts the read word.
REQ-011 ram_a_we  output  2  RAM write-enable code; ram_a_addr output 9; ram_a_data output `PIXEL_WIDTH*8.
REQ-012 ram_b_re  output  1  RAM read enable; ram_b_addr output 9; ram_b_data input `PIXEL_WIDTH*8, valid one cycle after ram_b_re.
REQ-013 err_ovf  output  1  sticky overflow flag (present only per REQ-030).

Function
REQ-014 RAM split into bank 0 (addr[8]=0) and bank 1 (addr[8]=1); each bank has state EMPTY, FILLING, FULL, DRAINING and a 9-bit length register (1..256).
REQ-015 Write pointer wbank and read pointer rbank SHALL each toggle 0->1->0 only on bank completion.
REQ-016 wr_ready = 1 iff state[wbank] is EMPTY or FILLING; combinational, no dependency on wr_valid.
REQ-017 Accepted write (wr_valid & wr_ready & wr_half!=11): ram_a_we=wr_half, ram_a_addr={wbank,wcnt}, ram_a_data=wr_data same cycle; wcnt increments; EMPTY->FILLING.
REQ-018 wr_half=11 with wr_valid: word is a no-op (ram_a_we=11, no count, no state change) even if wr_last set.
REQ-019 Not accepting: ram_a_we=11.
REQ-020 Accepted word with wr_last, or 256th accepted word (wcnt=255): len[wbank]=wcnt+1, state->FULL, wcnt->0, wbank toggles, all at next edge; 256th word without wr_last sets overflow (REQ-030).
REQ-021 Read issue: when state[rbank] is FULL or DRAINING, rcnt<len[rbank], and output skid buffer (2 entries) has a free slot counting the in-flight word, assert ram_b_re=1, ram_b_addr={rbank,rcnt}; rcnt increments; FULL->DRAINING.
REQ-022 Returned RAM word pushed into skid buffer the cycle after issue, tagged last when rcnt was len-1 at issue.
REQ-023 rd_valid = skid buffer non-empty; head popped on rd_valid & rd_ready; rd_data/rd_last stable while rd_valid & !rd_ready.
REQ-024 After final read issued, state[rbank]->EMPTY and rbank toggles at that edge; next bank reads may issue the following cycle.
REQ-025 Latency: wr_last accepted at cycle T with reader idle -> ram_b_re at T+1, rd_valid at T+2; sustained throughput 1 word/cycle with rd_ready=1.
REQ-026 Write and read on different banks in the same cycle are independent; writer and reader never address the same bank simultaneously.
REQ-027 Both banks FULL: wr_ready=0 until reader frees a bank; no word lost.

Reset
REQ-028 rst_n=0 at an edge: both banks EMPTY, len=0, wbank=rbank=0, wcnt=rcnt=0, skid buffer empty, err_ovf=0; outputs wr_ready=1, rd_valid=0, rd_last=0, ram_b_re=0, ram_a_we=11, addresses 0.
REQ-029 Reset mid-block discards all buffered data; no partial bank survives.

Configuration
REQ-030 Macro COE_BUF_OVF_ERR_EN defined: err_ovf port exists, set on REQ-020 overflow, cleared only by reset; undefined: port absent, forced-last behaviour unchanged.

Verification
REQ-031 Write 16 words (0x0..0xF, last on 16th), rd_ready=1 -> 16 reads addr 0..15, data 0x0..0xF in order, rd_last on 16th, rd_valid at T+2.
REQ-032 Write blocks A (8 words) and B (4 words) back-to-back, rd_ready=0 -> both banks FULL, wr_ready=0; raise rd_ready -> A then B emitted, wr_ready=1 after A's last issue.
REQ-033 Toggle rd_ready 1/0 every cycle during 32-word drain -> no duplicate/lost words, rd_data held while stalled.
REQ-034 Write 300 words without wr_last -> bank 0 len=256 closes at word 256, word 257 lands at addr 256, err_ovf=1 (macro on) or port absent (off).
REQ-035 wr_half=01 on words then 11 with wr_last -> ram_a_we=01 for accepted words, 11-word ignored, bank stays FILLING.
REQ-036 Assert rst_n=0 mid-drain of 20-word block -> next cycle rd_valid=0, wr_ready=1, all state per REQ-028.
